// File: rtl/cpu_pkg.sv
// Stack-operation encoding shared by the LIFO stacks and the CPU control FSM.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PUSH    = 2'b01,
        POP     = 2'b10,
        REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_stack_op(input logic push, input logic pop);
        return stack_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Single-write-port, asynchronous-read register array backing the LIFO stack.
module stack_mem #(
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [WIDTH_DATA-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [WIDTH_DATA-1:0] rdata
);

    logic [WIDTH_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Hardware LIFO with registered top-of-stack, full/empty status and sticky
// overflow/underflow flags; push and pop are accepted every cycle.
module lifo_stack
    import cpu_pkg::*;
#(
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 16,
    parameter int CWIDTH     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stack_push,
    input  logic                  stack_pop,
    input  logic [WIDTH_DATA-1:0] stack_data_in,
    output logic [WIDTH_DATA-1:0] stack_data_out,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic [CWIDTH-1:0]     stack_count,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CWIDTH-1:0]     sp_q, sp_d;
    logic [WIDTH_DATA-1:0] top_q, top_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [AW-1:0]         mem_raddr;
    logic [WIDTH_DATA-1:0] mem_rdata;

    logic      full, empty;
    stack_op_e op;

    assign full  = (sp_q == CWIDTH'(DEPTH));
    assign empty = (sp_q == '0);
    assign op    = decode_stack_op(stack_push, stack_pop);

    // Word that becomes the new top after a pop: the entry below the current top.
    assign mem_raddr = AW'(sp_q - CWIDTH'(2));

    always_comb begin
        sp_d      = sp_q;
        top_d     = top_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        mem_we    = 1'b0;
        mem_waddr = AW'(sp_q);

        unique case (op)
            PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + CWIDTH'(1);
                    top_d  = stack_data_in;
                end
            end
            POP: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    sp_d  = sp_q - CWIDTH'(1);
                    top_d = (sp_q >= CWIDTH'(2)) ? mem_rdata : '0;
                end
            end
            REPLACE: begin
                mem_we = 1'b1;
                top_d  = stack_data_in;
                if (empty) begin
                    // Pop half is rejected, push half still lands in slot 0.
                    sp_d  = sp_q + CWIDTH'(1);
                    udf_d = 1'b1;
                end else begin
                    mem_waddr = AW'(sp_q - CWIDTH'(1));
                end
            end
            default: begin
            end
        endcase

        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    stack_mem #(
        .WIDTH_DATA (WIDTH_DATA),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (stack_data_in),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign stack_data_out  = top_q;
    assign stack_full      = full;
    assign stack_empty     = empty;
    assign stack_count     = sp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack (DEPTH=4): queue-based reference model checked every
// cycle, plus literal expectations along a directed scenario.
module tb_lifo_stack;

    localparam int WIDTH_DATA = 16;
    localparam int DEPTH      = 4;
    localparam int CWIDTH     = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  stack_push = 1'b0;
    logic                  stack_pop = 1'b0;
    logic [WIDTH_DATA-1:0] stack_data_in = '0;
    logic [WIDTH_DATA-1:0] stack_data_out;
    logic                  stack_full;
    logic                  stack_empty;
    logic [CWIDTH-1:0]     stack_count;
    logic                  stack_overflow;
    logic                  stack_underflow;

    int checks   = 0;
    int failures = 0;

    lifo_stack #(
        .WIDTH_DATA (WIDTH_DATA),
        .DEPTH      (DEPTH),
        .CWIDTH     (CWIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stack_push      (stack_push),
        .stack_pop       (stack_pop),
        .stack_data_in   (stack_data_in),
        .stack_data_out  (stack_data_out),
        .stack_full      (stack_full),
        .stack_empty     (stack_empty),
        .stack_count     (stack_count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, top at the back.
    int model_q[$];
    bit model_ovf = 0;
    bit model_udf = 0;
    bit model_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            model_q.delete();
            model_ovf   = 0;
            model_udf   = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (stack_push && stack_pop) begin
                if (model_q.size() == 0) begin
                    model_q.push_back(int'(stack_data_in));
                    model_udf = 1;
                end else begin
                    model_q[model_q.size()-1] = int'(stack_data_in);
                end
            end else if (stack_push) begin
                if (model_q.size() < DEPTH) model_q.push_back(int'(stack_data_in));
                else model_ovf = 1;
            end else if (stack_pop) begin
                if (model_q.size() > 0) void'(model_q.pop_back());
                else model_udf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_count", int'(stack_count), model_q.size());
            chk("model_empty", int'(stack_empty), int'(model_q.size() == 0));
            chk("model_full",  int'(stack_full),  int'(model_q.size() == DEPTH));
            chk("model_dout",  int'(stack_data_out),
                (model_q.size() > 0) ? model_q[model_q.size()-1] : 0);
            chk("model_ovf",   int'(stack_overflow),  int'(model_ovf));
            chk("model_udf",   int'(stack_underflow), int'(model_udf));
        end
    end

    task automatic do_op(input bit push, input bit pop, input int din);
        @(negedge clk);
        stack_push    = push;
        stack_pop     = pop;
        stack_data_in = WIDTH_DATA'(din);
        @(posedge clk);
        #1;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset         = 1'b1;
            stack_push    = 1'($urandom_range(0, 1));
            stack_pop     = 1'($urandom_range(0, 1));
            stack_data_in = WIDTH_DATA'($urandom);
        end
        @(negedge clk);
        reset      = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
    endtask

    initial begin
        // Reset with random strobes
        do_reset(3);
        chk("rst_count", int'(stack_count), 0);
        chk("rst_empty", int'(stack_empty), 1);
        chk("rst_full",  int'(stack_full), 0);
        chk("rst_dout",  int'(stack_data_out), 0);
        chk("rst_ovf",   int'(stack_overflow), 0);
        chk("rst_udf",   int'(stack_underflow), 0);

        do_op(1, 0, 5);  chk("push5_dout", int'(stack_data_out), 5);
        do_op(1, 0, 2);  chk("push2_dout", int'(stack_data_out), 2);
        chk("push2_count", int'(stack_count), 2);
        do_op(0, 1, 0);  chk("pop1_dout", int'(stack_data_out), 5);
        chk("pop1_count", int'(stack_count), 1);
        do_op(0, 1, 0);  chk("pop2_dout", int'(stack_data_out), 0);
        chk("pop2_empty", int'(stack_empty), 1);

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) do_op(1, 0, i);
        chk("fill_full", int'(stack_full), 1);
        chk("fill_dout", int'(stack_data_out), 4);
        do_op(1, 0, 9);
        chk("ovf_flag",  int'(stack_overflow), 1);
        chk("ovf_dout",  int'(stack_data_out), 4);
        chk("ovf_count", int'(stack_count), 4);
        for (int i = 3; i >= 0; i--) begin
            do_op(0, 1, 0);
            chk("drain_dout", int'(stack_data_out), i);
        end

        // Underflow is sticky
        do_op(0, 1, 0);
        chk("udf_flag",  int'(stack_underflow), 1);
        chk("udf_count", int'(stack_count), 0);
        do_op(1, 0, 7);
        chk("udf_push_dout", int'(stack_data_out), 7);
        chk("udf_sticky",    int'(stack_underflow), 1);

        // Replace (push+pop together)
        do_reset(1);
        do_op(1, 0, 5);
        do_op(1, 0, 2);
        do_op(1, 1, 7);
        chk("repl_count", int'(stack_count), 2);
        chk("repl_dout",  int'(stack_data_out), 7);
        do_op(0, 1, 0);
        chk("repl_pop_dout", int'(stack_data_out), 5);
        do_op(1, 0, 10);
        do_op(1, 0, 11);
        do_op(1, 0, 12);
        chk("repl_fill_full", int'(stack_full), 1);
        do_op(1, 1, 13);
        chk("repl_full_ovf",   int'(stack_overflow), 0);
        chk("repl_full_count", int'(stack_count), 4);
        chk("repl_full_dout",  int'(stack_data_out), 13);
        do_op(0, 1, 0);
        chk("repl_full_pop", int'(stack_data_out), 11);
        // Strobe held for three cycles: three back-to-back pops
        @(negedge clk);
        stack_pop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stack_pop = 1'b0;
        chk("held_pop_empty", int'(stack_empty), 1);
        do_op(1, 1, 6);
        chk("repl_empty_count", int'(stack_count), 1);
        chk("repl_empty_udf",   int'(stack_underflow), 1);
        chk("repl_empty_dout",  int'(stack_data_out), 6);

        // Reset coinciding with a pop
        do_reset(1);
        do_op(1, 0, 1);
        do_op(1, 0, 2);
        do_op(1, 0, 3);
        @(negedge clk);
        reset     = 1'b1;
        stack_pop = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        stack_pop = 1'b0;
        chk("rstpop_count", int'(stack_count), 0);
        chk("rstpop_empty", int'(stack_empty), 1);
        chk("rstpop_dout",  int'(stack_data_out), 0);
        do_op(1, 0, 8);
        chk("post_rst_dout",  int'(stack_data_out), 8);
        chk("post_rst_count", int'(stack_count), 1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
